mem_stage_port: RTL and testbench

Memory-stage data-memory access controller for the 24-bit pipelined processor. It produces `ReadDataM` for the Memory/Writeback pipeline register. It converts the single-cycle `MemReadM`/`MemWriteM` intent from the Execute/Memory register into a req/ready handshake with a variable-latency data memory, stalling the pipeline until the access completes. It includes a timeout with a sticky fault flag, so a dead memory cannot hang the core.

---
 rtl/mem_port_pkg.sv | 16 +
 rtl/mem_timeout_counter.sv | 30 +++
 rtl/mem_stage_port.sv | 141 ++++++++++++++
 tb/tb_mem_stage_port.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_pkg.sv
// Shared types and defaults for the memory-stage data-memory port.
package mem_port_pkg;

    // Default data/address width of the core.
    localparam int N_DEFAULT       = 24;
    // Default number of REQ cycles allowed before an access is declared dead.
    localparam int TIMEOUT_DEFAULT = 16;

    // Access controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_timeout_counter.sv
// Cycle counter that flags the final REQ cycle before an access times out.
module mem_timeout_counter #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] count_q;

    // Count enabled cycles, saturating at TIMEOUT; clear wins over enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && (count_q != W'(TIMEOUT))) begin
            count_q <= count_q + W'(1);
        end
    end

    // The count reaches TIMEOUT at the end of this enabled cycle.
    assign expired = enable && (count_q == W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage_port.sv
// Memory-stage access controller: turns single-cycle MemReadM/MemWriteM
// intent into a req/ready transaction with a variable-latency data memory,
// stalling the pipeline until it completes or times out.
//
// Handshake: mem_req is high for every REQ cycle and mem_addr, mem_wdata and
// mem_we are held stable while it is high. A transfer completes on the first
// cycle with mem_req && mem_ready; mem_rdata is only sampled on that cycle.
// mem_ready while mem_req is low is ignored.
module mem_stage_port
    import mem_port_pkg::*;
#(
    parameter int N       = N_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         MemReadM,
    input  logic         MemWriteM,
    input  logic [N-1:0] ALUOutM,
    input  logic [N-1:0] WriteDataM,
    output logic [N-1:0] ReadDataM,
    output logic         StallMem,
    output logic         MemFault,
    output logic         mem_req,
    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    input  logic         mem_ready,
    input  logic [N-1:0] mem_rdata,
    output mem_state_t   fsm_state
);

    mem_state_t   state_q;
    mem_state_t   state_d;
    logic         access;
    logic         start;
    logic         expired;
    logic         stall_raw;
    logic [N-1:0] rbuf_q;
    logic [N-1:0] addr_q;
    logic [N-1:0] wdata_q;
    logic         we_q;
    logic         fault_q;

    assign access = MemReadM | MemWriteM;
    // A new access is only accepted in IDLE; in DONE the controls still
    // belong to the instruction that just finished.
    assign start  = (state_q == IDLE) && access;

    mem_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (start),
        .enable  (state_q == REQ),
        .expired (expired)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and combinational stall request.
    always_comb begin
        state_d   = state_q;
        stall_raw = 1'b0;
        case (state_q)
            IDLE: begin
                if (access) begin
                    state_d   = REQ;
                    stall_raw = 1'b1;
                end
            end
            REQ: begin
                stall_raw = 1'b1;
                if (mem_ready || expired) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Latch the access on acceptance; held unchanged through REQ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else if (start) begin
            addr_q  <= ALUOutM;
            wdata_q <= WriteDataM;
            // A simultaneous read and write request is treated as a write.
            we_q    <= MemWriteM;
        end
    end

    // Read buffer: load data on completion, zero for stores and timeouts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rbuf_q <= '0;
        end else if (state_q == REQ) begin
            if (mem_ready) begin
                rbuf_q <= we_q ? '0 : mem_rdata;
            end else if (expired) begin
                rbuf_q <= '0;
            end
        end
    end

    // Sticky fault flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else if ((state_q == REQ) && !mem_ready && expired) begin
            fault_q <= 1'b1;
        end
    end

    // No stall is requested while the core is held in reset.
    assign StallMem  = rst_n && stall_raw;
    assign mem_req   = (state_q == REQ);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign ReadDataM = rbuf_q;
    assign MemFault  = fault_q;
    assign fsm_state = state_q;

endmodule

// File: tb/tb_mem_stage_port.sv
// Directed bench for mem_stage_port with a short timeout.
module tb_mem_stage_port;
    import mem_port_pkg::*;

    localparam int N  = 24;
    localparam int TO = 4;

    logic         clk;
    logic         rst_n;
    logic         MemReadM;
    logic         MemWriteM;
    logic [N-1:0] ALUOutM;
    logic [N-1:0] WriteDataM;
    logic [N-1:0] ReadDataM;
    logic         StallMem;
    logic         MemFault;
    logic         mem_req;
    logic         mem_we;
    logic [N-1:0] mem_addr;
    logic [N-1:0] mem_wdata;
    logic         mem_ready;
    logic [N-1:0] mem_rdata;
    mem_state_t   fsm_state;

    int n_vec;
    int n_err;
    int cyc;

    mem_stage_port #(
        .N       (N),
        .TIMEOUT (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .StallMem   (StallMem),
        .MemFault   (MemFault),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .fsm_state  (fsm_state)
    );

    // Clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete access. k = cycle of REQ on which mem_ready arrives
    // (0 = never). With chain set, the next access starts right after DONE.
    task automatic do_access(input string tag, input logic rd, input logic wr,
                             input logic [N-1:0] addr, input logic [N-1:0] wdata,
                             input logic [N-1:0] rdata, input int k,
                             input logic exp_fault, input logic chain,
                             output int done_cyc, output int req_cyc);
        int stall_cnt;
        int req_cnt;
        logic [N-1:0] exp_rd;
        exp_rd    = (wr || k == 0) ? '0 : rdata;
        stall_cnt = 0;
        req_cnt   = 0;
        req_cyc   = -1;
        @(posedge clk); #1;
        MemReadM   = rd;
        MemWriteM  = wr;
        ALUOutM    = addr;
        WriteDataM = wdata;
        mem_ready  = 1'b0;
        @(negedge clk);
        check_eq({tag, "_stall_idle"}, 32'(StallMem), 32'd1);
        check_eq({tag, "_req_idle"}, 32'(mem_req), 32'd0);
        if (StallMem) stall_cnt++;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            mem_ready = (k > 0) && (i == k);
            mem_rdata = mem_ready ? rdata : N'($urandom);
            @(negedge clk);
            if (fsm_state != REQ) break;
            if (req_cyc < 0) req_cyc = cyc;
            req_cnt++;
            if (StallMem) stall_cnt++;
            check_eq({tag, "_addr"}, 32'(mem_addr), 32'(addr));
            check_eq({tag, "_wdata"}, 32'(mem_wdata), 32'(wdata));
            check_eq({tag, "_we"}, 32'(mem_we), 32'(wr));
            check_eq({tag, "_req"}, 32'(mem_req), 32'd1);
        end
        done_cyc = cyc;
        check_eq({tag, "_done_state"}, 32'(fsm_state), 32'(DONE));
        check_eq({tag, "_req_cycles"}, 32'(req_cnt), 32'((k > 0) ? k : TO));
        check_eq({tag, "_stall_cycles"}, 32'(stall_cnt), 32'((k > 0) ? k + 1 : TO + 1));
        check_eq({tag, "_done_stall"}, 32'(StallMem), 32'd0);
        check_eq({tag, "_done_req"}, 32'(mem_req), 32'd0);
        check_eq({tag, "_rdata"}, 32'(ReadDataM), 32'(exp_rd));
        check_eq({tag, "_fault"}, 32'(MemFault), 32'(exp_fault));
        if (!chain) begin
            @(posedge clk); #1;
            MemReadM  = 1'b0;
            MemWriteM = 1'b0;
            @(negedge clk);
            check_eq({tag, "_back_idle"}, 32'(fsm_state), 32'(IDLE));
            check_eq({tag, "_idle_stall"}, 32'(StallMem), 32'd0);
            check_eq({tag, "_rdata_hold"}, 32'(ReadDataM), 32'(exp_rd));
            check_eq({tag, "_fault_hold"}, 32'(MemFault), 32'(exp_fault));
        end
    endtask

    initial begin
        int d1, r1, d2, r2;
        n_vec      = 0;
        n_err      = 0;
        cyc        = 0;
        rst_n      = 1'b0;
        MemReadM   = 1'b0;
        MemWriteM  = 1'b0;
        ALUOutM    = '0;
        WriteDataM = '0;
        mem_ready  = 1'b0;
        mem_rdata  = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        check_eq("rst_state", 32'(fsm_state), 32'(IDLE));
        check_eq("rst_req", 32'(mem_req), 32'd0);
        check_eq("rst_we", 32'(mem_we), 32'd0);
        check_eq("rst_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_wdata", 32'(mem_wdata), 32'd0);
        check_eq("rst_rdata", 32'(ReadDataM), 32'd0);
        check_eq("rst_fault", 32'(MemFault), 32'd0);
        check_eq("rst_stall", 32'(StallMem), 32'd0);
        rst_n = 1'b1;

        // Load, ready on first REQ cycle.
        do_access("ld_k1", 1'b1, 1'b0, 24'h000010, 24'h000000, 24'hABCDEF, 1, 1'b0, 1'b0, d1, r1);

        // Spurious ready while idle.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            mem_ready = 1'b1;
            mem_rdata = 24'h555555;
            @(negedge clk);
            check_eq("spur_stall", 32'(StallMem), 32'd0);
            check_eq("spur_state", 32'(fsm_state), 32'(IDLE));
            check_eq("spur_req", 32'(mem_req), 32'd0);
            check_eq("spur_rdata", 32'(ReadDataM), 32'hABCDEF);
        end

        // Store, ready on third REQ cycle.
        do_access("st_k3", 1'b0, 1'b1, 24'h000020, 24'h123456, 24'h987654, 3, 1'b0, 1'b0, d1, r1);

        // Read and write together behave as a write.
        do_access("rw_k2", 1'b1, 1'b1, 24'h000040, 24'h0F0F0F, 24'hFEDCBA, 2, 1'b0, 1'b0, d1, r1);

        // Back-to-back loads.
        do_access("b2b_a", 1'b1, 1'b0, 24'h000001, 24'h000000, 24'h111111, 2, 1'b0, 1'b1, d1, r1);
        do_access("b2b_b", 1'b1, 1'b0, 24'h000002, 24'h000000, 24'h222222, 1, 1'b0, 1'b0, d2, r2);
        check_eq("b2b_gap", 32'(r2 - d1), 32'd2);

        // Timeout with memory silent.
        do_access("tmo", 1'b1, 1'b0, 24'h000080, 24'h000000, 24'h777777, 0, 1'b1, 1'b0, d1, r1);

        // Fault stays set across a later good load.
        do_access("after_tmo", 1'b1, 1'b0, 24'h000090, 24'h000000, 24'h3C3C3C, 1, 1'b1, 1'b0, d1, r1);

        // Reset in the middle of REQ.
        @(posedge clk); #1;
        MemReadM = 1'b1;
        ALUOutM  = 24'h000030;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(negedge clk);
        check_eq("mid_req_up", 32'(mem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_req", 32'(mem_req), 32'd0);
        check_eq("mid_rst_stall", 32'(StallMem), 32'd0);
        check_eq("mid_rst_rdata", 32'(ReadDataM), 32'd0);
        check_eq("mid_rst_fault", 32'(MemFault), 32'd0);
        MemReadM = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            mem_ready = (i == 1);
            @(negedge clk);
            check_eq("mid_no_done", 32'(fsm_state), 32'(IDLE));
            check_eq("mid_no_req", 32'(mem_req), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog.
    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
